// File: rtl/fpcvt_serial_loader.sv
// Purpose : deserialize 13-bit two's-complement frames (MSB first, optional even
//           parity bit) into a parallel word held for the downstream converter.
// Latency : D/d_valid update on the edge that samples the frame's last bit.
// Backpressure: one holding register; a frame completing while it is full and
//           not being consumed is dropped and flagged with an overrun pulse.
// Ports   : clk, rst_n (sync, active-low); sin/sin_en/sin_start serial input;
//           D/d_valid/d_ready parallel output handshake; frame_err, overrun
//           (one-cycle pulses), busy (frame in progress).
module fpcvt_serial_loader #(
  parameter int WIDTH     = 13,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sin_start,
  output logic [WIDTH-1:0] D,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [3:0]       cnt_q;
  logic             par_q;
  logic [WIDTH-1:0] d_q;
  logic             d_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  // Shift-register contents including the bit currently on sin.
  logic [WIDTH-1:0] sh_shift_d;
  // Frame completes on this edge, and the word it delivers.
  logic             complete_d;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    sh_shift_d = {sh_q[WIDTH-2:0], sin};
    complete_d = 1'b0;
    word_d     = sh_shift_d;
    // A start strobe always aborts, so it can never complete a frame.
    if (sin_en && !sin_start) begin
      if (state_q == SHIFT && cnt_q == 4'd0 && !PARITY_EN) begin
        complete_d = 1'b1;
      end
      if (state_q == PARITY && (par_q ^ sin) == 1'b0) begin
        // Data is already fully shifted in; the parity bit is not data.
        complete_d = 1'b1;
        word_d     = sh_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= 4'd0;
      par_q       <= 1'b0;
      d_q         <= '0;
      d_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumption first; a completion on the same edge overrides it below.
      if (d_valid_q && d_ready) begin
        d_valid_q <= 1'b0;
      end

      if (complete_d) begin
        if (!d_valid_q || d_ready) begin
          d_q       <= word_d;
          d_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      if (sin_en) begin
        case (state_q)
          IDLE: begin
            if (sin_start) begin
              sh_q    <= {{(WIDTH-1){1'b0}}, sin};
              par_q   <= sin;
              cnt_q   <= 4'(WIDTH - 2);
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (sin_start) begin
              // Abort: this bit is the MSB of a fresh frame.
              frame_err_q <= 1'b1;
              sh_q        <= {{(WIDTH-1){1'b0}}, sin};
              par_q       <= sin;
              cnt_q       <= 4'(WIDTH - 2);
            end else begin
              sh_q  <= sh_shift_d;
              par_q <= par_q ^ sin;
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd0) begin
                state_q <= PARITY_EN ? PARITY : IDLE;
              end
            end
          end
          PARITY: begin
            if (sin_start) begin
              frame_err_q <= 1'b1;
              sh_q        <= {{(WIDTH-1){1'b0}}, sin};
              par_q       <= sin;
              cnt_q       <= 4'(WIDTH - 2);
              state_q     <= SHIFT;
            end else begin
              if ((par_q ^ sin) != 1'b0) begin
                frame_err_q <= 1'b1;
              end
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign D         = d_q;
  assign d_valid   = d_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpcvt_serial_loader.sv
// Bench for fpcvt_serial_loader: a parity-enabled and a parity-disabled instance
// share the serial inputs; a frame-level reference model predicts the results.
module tb_fpcvt_serial_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b0;
  logic        sin_en = 1'b0;
  logic        sin_start = 1'b0;
  logic        d_ready = 1'b0;

  logic [12:0] d0, d1;
  logic        v0, e0, o0, b0;
  logic        v1, e1, o1, b1;

  int checks = 0;
  int errors = 0;

  // Reference model state: the word the consumer should currently see.
  logic [12:0] exp_d;
  logic        exp_v;

  // Selects which instance the frame tasks observe.
  logic        sel_np = 1'b0;
  logic [12:0] obs_d;
  logic        obs_v, obs_e, obs_o, obs_b;

  fpcvt_serial_loader #(.WIDTH(13), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sin_start(sin_start),
    .D(d0), .d_valid(v0), .d_ready(d_ready), .frame_err(e0), .overrun(o0), .busy(b0)
  );

  fpcvt_serial_loader #(.WIDTH(13), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sin_start(sin_start),
    .D(d1), .d_valid(v1), .d_ready(d_ready), .frame_err(e1), .overrun(o1), .busy(b1)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (sel_np) begin
      obs_d = d1; obs_v = v1; obs_e = e1; obs_o = o1; obs_b = b1;
    end else begin
      obs_d = d0; obs_v = v0; obs_e = e0; obs_o = o0; obs_b = b0;
    end
  end

  task automatic strobe(input logic b, input logic st);
    sin       = b;
    sin_start = st;
    sin_en    = 1'b1;
    @(posedge clk); #1;
    sin_en    = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First n bits (MSB first) of val, starting a frame, then stop.
  task automatic send_bits(input logic [12:0] val, input int n);
    for (int i = 0; i < n; i++) strobe(val[12-i], i == 0);
  endtask

  // Sends one complete frame and checks its outcome against the model.
  task automatic send_frame(input logic [12:0] val, input logic pbit, input bit use_par,
                            input int gap, input bit rdy_body, input bit rdy_last,
                            input bit exp_abort, input bit b2b, input string name);
    int   nbits;
    int   nbusy;
    bit   good;
    bit   ovr;
    logic b;
    nbits  = use_par ? 14 : 13;
    nbusy  = 0;
    sel_np = !use_par;
    good   = !use_par || (pbit == ^val);
    d_ready = rdy_body;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 13) ? val[12-i] : pbit;
      if (i == nbits - 1) d_ready = rdy_last;
      strobe(b, i == 0);
      if (i == 0) begin
        checks++;
        if (obs_e !== exp_abort) begin
          errors++;
          $display("FAIL %s start_err: got %b want %b", name, obs_e, exp_abort);
        end
      end
      if (i < nbits - 1 && obs_b === 1'b1) nbusy++;
      if (i < nbits - 1 && gap > 0) idle(gap);
    end
    d_ready = 1'b0;

    // Frame-level model: any body cycle with ready drains the old word.
    if (rdy_body) exp_v = 1'b0;
    ovr = 1'b0;
    if (good) begin
      if (!exp_v || rdy_last) begin
        exp_d = val;
        exp_v = 1'b1;
      end else begin
        ovr = 1'b1;
      end
    end else if (rdy_last) begin
      exp_v = 1'b0;
    end

    checks++;
    if (obs_d !== exp_d || obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s data: got D=%h v=%b want D=%h v=%b", name, obs_d, obs_v, exp_d, exp_v);
    end
    checks++;
    if (obs_e !== !good || obs_o !== ovr) begin
      errors++;
      $display("FAIL %s flags: got err=%b ovr=%b want err=%b ovr=%b", name, obs_e, obs_o, !good, ovr);
    end
    checks++;
    if (nbusy != nbits - 1 || obs_b !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %0d strobes busy, end=%b want %0d, end=0", name, nbusy, obs_b, nbits - 1);
    end
    if (!b2b) begin
      idle(1);
      checks++;
      if (obs_e !== 1'b0 || obs_o !== 1'b0 || obs_d !== exp_d || obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s hold: got err=%b ovr=%b D=%h v=%b want 0 0 %h %b",
                 name, obs_e, obs_o, obs_d, obs_v, exp_d, exp_v);
      end
    end
  endtask

  task automatic drain();
    d_ready = 1'b1;
    idle(1);
    d_ready = 1'b0;
    exp_v = 1'b0;
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL drain: got v=%b want 0", v0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_d = '0;
    exp_v = 1'b0;
    checks++;
    if ({d0, v0, e0, o0, b0} !== 17'd0 || {d1, v1, e1, o1, b1} !== 17'd0) begin
      errors++;
      $display("FAIL reset: got p=%h/%b%b%b%b np=%h/%b%b%b%b want all 0",
               d0, v0, e0, o0, b0, d1, v1, e1, o1, b1);
    end
  endtask

  task automatic test_basic();
    send_frame(13'd40, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "pos40");
    // -400 with sin_en every other cycle
    send_frame(13'h1E70, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, "neg400");
  endtask

  task automatic test_parity_err();
    send_frame(13'd4095, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "bad_parity");
  endtask

  task automatic test_overrun();
    drain();
    send_frame(13'h1000, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "min_load");
    send_frame(13'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "overrun");
    send_frame(13'd0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "simul_ready");
  endtask

  task automatic test_abort();
    send_bits(13'h0ABC, 6);
    send_frame(13'd40, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, "abort");
  endtask

  task automatic test_back_to_back();
    logic [12:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 13'($urandom);
      send_frame(v, ^v, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, "b2b");
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [12:0] v;
    logic        p;
    for (int k = 0; k < 16; k++) begin
      v = 13'($urandom);
      p = (^v) ^ ($urandom_range(0, 4) == 0);
      send_frame(v, p, 1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), "random");
    end
    idle(1);
  endtask

  task automatic test_midframe_reset();
    send_bits(13'h1555, 7);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp_d = '0;
    exp_v = 1'b0;
    checks++;
    if ({d0, v0, e0, o0, b0} !== 17'd0) begin
      errors++;
      $display("FAIL midreset: got D=%h v=%b err=%b ovr=%b busy=%b want all 0", d0, v0, e0, o0, b0);
    end
    send_frame(13'd15, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_no_parity();
    logic [12:0] v;
    test_reset();
    send_frame(13'd253, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "np253");
    for (int k = 0; k < 4; k++) begin
      v = 13'($urandom);
      send_frame(v, 1'b0, 1'b0, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0, "np_random");
    end
    sel_np = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    test_midframe_reset();
    test_no_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
